// File: rtl/ex_stage_mdu_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage: decoded fields in,
// registered EX/MEM fields and the upstream stall out.
`timescale 1ns/1ps
interface ex_stage_mdu_if #(parameter int WIDTH = 32);
   logic             RegWrite, MemtoReg, MemWrite, Branch;
   logic             ALUSrc, ALUSrc_shamt, RegDst;
   logic [3:0]       ALUControl;
   logic [WIDTH-1:0] RD1, RD2, SignImm, PCplus4;
   logic [4:0]       Rt, Rd, shamt;
   logic             Flush_E;
   logic             Stall;
   logic             RegWrite_M, MemtoReg_M, MemWrite_M, Branch_M, Zero_M;
   logic [WIDTH-1:0] ALUOut_M, WriteData_M, PCBranch_M;
   logic [4:0]       WriteReg_M;

   modport slave (
      input  RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSrc_shamt, RegDst,
      input  ALUControl, RD1, RD2, SignImm, PCplus4, Rt, Rd, shamt, Flush_E,
      output Stall, RegWrite_M, MemtoReg_M, MemWrite_M, Branch_M, Zero_M,
      output ALUOut_M, WriteData_M, PCBranch_M, WriteReg_M
   );

   modport master (
      output RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSrc_shamt, RegDst,
      output ALUControl, RD1, RD2, SignImm, PCplus4, Rt, Rd, shamt, Flush_E,
      input  Stall, RegWrite_M, MemtoReg_M, MemWrite_M, Branch_M, Zero_M,
      input  ALUOut_M, WriteData_M, PCBranch_M, WriteReg_M
   );
endinterface

// File: rtl/ex_stage_mdu.sv
// EX stage: single-cycle ALU plus an iterative shift-add multiplier that
// stalls upstream and feeds bubbles into EX/MEM while it runs.
`timescale 1ns/1ps
module ex_stage_mdu #(
   parameter int WIDTH      = 32,
   parameter bit MUL_ENABLE = 1'b1
) (
   input logic           CLK,
   input logic           RST,
   ex_stage_mdu_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;

   logic             rw_q, mtr_q, mw_q, br_q, zero_q;
   logic             rw_d, mtr_d, mw_d, br_d, zero_d;
   logic [WIDTH-1:0] alu_q, wd_q, pcb_q, alu_d, wd_d, pcb_d;
   logic [4:0]       wr_q, wr_d;

   logic [WIDTH-1:0] src_a, src_b, alu_res, result;
   logic             mul_req, stall, bubble, use_acc;

   function automatic logic [WIDTH-1:0] alu(input logic [3:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] sa, sb;
      sa = a;
      sb = b;
      case (op)
         4'b0000: alu = a & b;
         4'b0001: alu = a | b;
         4'b0010: alu = a + b;
         4'b0110: alu = a - b;
         4'b0111: alu = (sa < sb) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
         4'b1100: alu = ~(a | b);
         4'b1000: alu = a ^ b;
         4'b0011: alu = b << a[4:0];
         4'b0100: alu = b >> a[4:0];
         4'b0101: alu = sb >>> a[4:0];
         default: alu = '0;
      endcase
   endfunction

   assign src_a   = bus.ALUSrc_shamt ? {{(WIDTH-5){1'b0}}, bus.shamt} : bus.RD1;
   assign src_b   = bus.ALUSrc ? bus.SignImm : bus.RD2;
   assign alu_res = alu(bus.ALUControl, src_a, src_b);
   assign mul_req = MUL_ENABLE && (bus.ALUControl == 4'b1001);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      stall    = 1'b0;
      bubble   = 1'b0;
      use_acc  = 1'b0;
      // A flush squashes the EX instruction, including any multiply in flight
      if (bus.Flush_E) begin
         state_d = IDLE;
         bubble  = 1'b1;
      end else begin
         case (state_q)
            IDLE: if (mul_req) begin
               stall    = 1'b1;
               bubble   = 1'b1;
               mcand_d  = src_a;
               mplier_d = src_b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = BUSY;
            end
            BUSY: begin
               stall    = 1'b1;
               bubble   = 1'b1;
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
            end
            DONE: begin
               use_acc = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      result = use_acc ? acc_q : alu_res;
      rw_d   = bus.RegWrite;
      mtr_d  = bus.MemtoReg;
      mw_d   = bus.MemWrite;
      br_d   = bus.Branch;
      zero_d = (result == '0);
      alu_d  = result;
      wd_d   = bus.RD2;
      pcb_d  = bus.PCplus4 + (bus.SignImm << 2);
      wr_d   = bus.RegDst ? bus.Rd : bus.Rt;
      if (bubble) begin
         rw_d   = 1'b0;
         mtr_d  = 1'b0;
         mw_d   = 1'b0;
         br_d   = 1'b0;
         zero_d = 1'b0;
         alu_d  = '0;
         wd_d   = '0;
         pcb_d  = '0;
         wr_d   = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         mtr_q   <= 1'b0;
         mw_q    <= 1'b0;
         br_q    <= 1'b0;
         zero_q  <= 1'b0;
         alu_q   <= '0;
         wd_q    <= '0;
         pcb_q   <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         mtr_q   <= mtr_d;
         mw_q    <= mw_d;
         br_q    <= br_d;
         zero_q  <= zero_d;
         alu_q   <= alu_d;
         wd_q    <= wd_d;
         pcb_q   <= pcb_d;
         wr_q    <= wr_d;
      end
   end

   // Multiplier datapath is always reloaded on start, so it carries no reset
   always_ff @(posedge CLK) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
   end

   assign bus.Stall       = stall & ~RST;
   assign bus.RegWrite_M  = rw_q;
   assign bus.MemtoReg_M  = mtr_q;
   assign bus.MemWrite_M  = mw_q;
   assign bus.Branch_M    = br_q;
   assign bus.Zero_M      = zero_q;
   assign bus.ALUOut_M    = alu_q;
   assign bus.WriteData_M = wd_q;
   assign bus.PCBranch_M  = pcb_q;
   assign bus.WriteReg_M  = wr_q;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Scoreboard bench for ex_stage_mdu: directed ALU, MUL, flush and reset
// vectors, plus a MUL_ENABLE=0 instance sharing the same input stream.
`timescale 1ns/1ps
module tb_ex_stage_mdu;
   typedef struct packed {
      logic        rw, mtr, mw, br, zero;
      logic [31:0] alu, wd, pcb;
      logic [4:0]  wr;
   } exp_t;

   typedef struct packed {
      logic st;
      exp_t o;
      logic v1;
      exp_t o1;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   bit   started = 1'b0;
   exp_t prev = '0;
   ent_t q[$];

   ex_stage_mdu_if #(.WIDTH(32)) if0 ();
   ex_stage_mdu_if #(.WIDTH(32)) if1 ();

   ex_stage_mdu #(.WIDTH(32), .MUL_ENABLE(1'b1)) dut  (.CLK(clk), .RST(rst), .bus(if0));
   ex_stage_mdu #(.WIDTH(32), .MUL_ENABLE(1'b0)) dut1 (.CLK(clk), .RST(rst), .bus(if1));

   assign if1.RegWrite     = if0.RegWrite;
   assign if1.MemtoReg     = if0.MemtoReg;
   assign if1.MemWrite     = if0.MemWrite;
   assign if1.Branch       = if0.Branch;
   assign if1.ALUSrc       = if0.ALUSrc;
   assign if1.ALUSrc_shamt = if0.ALUSrc_shamt;
   assign if1.RegDst       = if0.RegDst;
   assign if1.ALUControl   = if0.ALUControl;
   assign if1.RD1          = if0.RD1;
   assign if1.RD2          = if0.RD2;
   assign if1.SignImm      = if0.SignImm;
   assign if1.PCplus4      = if0.PCplus4;
   assign if1.Rt           = if0.Rt;
   assign if1.Rd           = if0.Rd;
   assign if1.shamt        = if0.shamt;
   assign if1.Flush_E      = if0.Flush_E;

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic rw, mtr, mw, br, zero,
                               input logic [31:0] alu, wd, pcb,
                               input logic [4:0] wr);
      exp_t e;
      e.rw = rw; e.mtr = mtr; e.mw = mw; e.br = br; e.zero = zero;
      e.alu = alu; e.wd = wd; e.pcb = pcb; e.wr = wr;
      return e;
   endfunction

   function automatic exp_t got0();
      return mk(if0.RegWrite_M, if0.MemtoReg_M, if0.MemWrite_M, if0.Branch_M, if0.Zero_M,
                if0.ALUOut_M, if0.WriteData_M, if0.PCBranch_M, if0.WriteReg_M);
   endfunction

   function automatic exp_t got1();
      return mk(if1.RegWrite_M, if1.MemtoReg_M, if1.MemWrite_M, if1.Branch_M, if1.Zero_M,
                if1.ALUOut_M, if1.WriteData_M, if1.PCBranch_M, if1.WriteReg_M);
   endfunction

   // Monitor: pops one expectation per cycle and compares away from the edge
   always @(negedge clk) begin
      ent_t e;
      exp_t g;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (if0.Stall !== e.st) begin
            errors++;
            $display("FAIL stall t=%0t got %b want %b", $time, if0.Stall, e.st);
         end
         g = got0();
         checks++;
         if (g !== e.o) begin
            errors++;
            $display("FAIL exmem t=%0t got rw%b mtr%b mw%b br%b z%b alu=%h wd=%h pcb=%h wr=%0d want rw%b mtr%b mw%b br%b z%b alu=%h wd=%h pcb=%h wr=%0d",
                     $time, g.rw, g.mtr, g.mw, g.br, g.zero, g.alu, g.wd, g.pcb, g.wr,
                     e.o.rw, e.o.mtr, e.o.mw, e.o.br, e.o.zero, e.o.alu, e.o.wd, e.o.pcb, e.o.wr);
         end
         if (e.v1) begin
            g = got1();
            checks++;
            if (g !== e.o1) begin
               errors++;
               $display("FAIL nomul_exmem t=%0t got alu=%h z%b rw%b wr=%0d want alu=%h z%b rw%b wr=%0d",
                        $time, g.alu, g.zero, g.rw, g.wr, e.o1.alu, e.o1.zero, e.o1.rw, e.o1.wr);
            end
         end
      end
      if (started) begin
         checks++;
         if (if1.Stall !== 1'b0) begin
            errors++;
            $display("FAIL nomul_stall t=%0t got %b want 0", $time, if1.Stall);
         end
      end
   end

   task automatic clr();
      if0.RegWrite = 0; if0.MemtoReg = 0; if0.MemWrite = 0; if0.Branch = 0;
      if0.ALUSrc = 0; if0.ALUSrc_shamt = 0; if0.RegDst = 0; if0.ALUControl = 4'b0000;
      if0.RD1 = 0; if0.RD2 = 0; if0.SignImm = 0; if0.PCplus4 = 0;
      if0.Rt = 0; if0.Rd = 0; if0.shamt = 0; if0.Flush_E = 0;
   endtask

   // Queue this cycle's expectations, then advance one clock
   task automatic step(input logic st, input exp_t nxt,
                       input logic v1 = 1'b0, input exp_t o1 = '0);
      ent_t e;
      e.st = st; e.o = prev; e.v1 = v1; e.o1 = o1;
      q.push_back(e);
      prev = nxt;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      exp_t nop, o1;
      nop = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
      rst = 1'b1;
      clr();
      if0.ALUControl = 4'b0010; if0.RD1 = 5; if0.RD2 = 7; if0.RegWrite = 1; if0.Rt = 3;
      @(posedge clk); #1;
      started = 1'b1;

      // Reset held while a MUL is presented: outputs 0, Stall forced low
      if0.ALUControl = 4'b1001; if0.RD1 = 3; if0.RD2 = 5;
      step(0, '0);
      rst = 1'b0;

      clr(); if0.ALUControl = 4'b0010; if0.RD1 = 5; if0.RD2 = 7; if0.RegWrite = 1; if0.Rt = 3;
      step(0, mk(1, 0, 0, 0, 0, 32'd12, 32'd7, 0, 5'd3));
      clr(); if0.ALUControl = 4'b0110; if0.RD1 = 3; if0.RD2 = 3; if0.MemWrite = 1;
      step(0, mk(0, 0, 1, 0, 1, 0, 32'd3, 0, 0));
      clr(); if0.ALUControl = 4'b0111; if0.RD1 = 32'hFFFF_FFFF; if0.RD2 = 1; if0.RegWrite = 1; if0.Rt = 5;
      step(0, mk(1, 0, 0, 0, 0, 32'd1, 32'd1, 0, 5'd5));
      clr(); if0.ALUControl = 4'b0101; if0.ALUSrc_shamt = 1; if0.shamt = 4; if0.RD1 = 32'h1F;
      if0.RD2 = 32'h8000_0000; if0.RegDst = 1; if0.Rd = 9; if0.Rt = 2; if0.MemtoReg = 1; if0.RegWrite = 1;
      step(0, mk(1, 1, 0, 0, 0, 32'hF800_0000, 32'h8000_0000, 0, 5'd9));
      clr(); if0.ALUControl = 4'b0010; if0.ALUSrc = 1; if0.SignImm = 32'hFFFF_FFFF; if0.RD1 = 32'h10;
      if0.RD2 = 32'h20; if0.PCplus4 = 32'h100; if0.Branch = 1;
      step(0, mk(0, 0, 0, 1, 0, 32'hF, 32'h20, 32'hFC, 0));
      clr(); if0.ALUControl = 4'b0011; if0.RD1 = 8; if0.RD2 = 32'hFF;
      step(0, mk(0, 0, 0, 0, 0, 32'hFF00, 32'hFF, 0, 0));
      clr(); if0.ALUControl = 4'b0100; if0.RD1 = 32'h24; if0.RD2 = 32'h8000_0000;
      step(0, mk(0, 0, 0, 0, 0, 32'h0800_0000, 32'h8000_0000, 0, 0));
      clr(); if0.ALUControl = 4'b1100; if0.RD1 = 32'hF0F0_F0F0; if0.RD2 = 32'h0F0F_0000;
      step(0, mk(0, 0, 0, 0, 0, 32'h0000_0F0F, 32'h0F0F_0000, 0, 0));
      clr(); if0.ALUControl = 4'b1000; if0.RD1 = 32'hFF00_FF00; if0.RD2 = 32'h0FF0_0FF0;
      step(0, mk(0, 0, 0, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0));
      clr(); if0.ALUControl = 4'b0001; if0.RD1 = 32'h12; if0.RD2 = 32'h21;
      step(0, mk(0, 0, 0, 0, 0, 32'h33, 32'h21, 0, 0));
      clr(); if0.ALUControl = 4'b0000; if0.RD1 = 32'hF0; if0.RD2 = 32'h3C;
      step(0, mk(0, 0, 0, 0, 0, 32'h30, 32'h3C, 0, 0));
      clr(); if0.ALUControl = 4'b1111; if0.RD1 = 5; if0.RD2 = 6; if0.RegWrite = 1;
      step(0, mk(1, 0, 0, 0, 1, 0, 32'd6, 0, 0));
      clr(); if0.ALUControl = 4'b0010; if0.RD1 = 1; if0.RD2 = 1; if0.RegWrite = 1; if0.Flush_E = 1;
      step(0, '0);

      // MUL 0x12345 * 0x10: 33 stalled bubbles, result on the 34th edge
      clr(); if0.ALUControl = 4'b1001; if0.RD1 = 32'h12345; if0.RD2 = 32'h10; if0.RegWrite = 1;
      if0.RegDst = 1; if0.Rd = 7; if0.PCplus4 = 32'h40; if0.SignImm = 1;
      for (int i = 0; i < 33; i++) step(1, '0);
      step(0, mk(1, 0, 0, 0, 0, 32'h0012_3450, 32'h10, 32'h44, 5'd7));

      // Back-to-back MULs: -1 * 2 via immediate, then a product whose low word is 0
      clr(); if0.ALUControl = 4'b1001; if0.ALUSrc = 1; if0.SignImm = 2; if0.RD1 = 32'hFFFF_FFFF;
      if0.RD2 = 32'h55; if0.RegWrite = 1; if0.Rt = 4;
      for (int i = 0; i < 33; i++) step(1, '0);
      step(0, mk(1, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'h55, 32'h8, 5'd4));
      clr(); if0.ALUControl = 4'b1001; if0.RD1 = 32'h10000; if0.RD2 = 32'h10000; if0.RegWrite = 1; if0.Rt = 6;
      for (int i = 0; i < 33; i++) step(1, '0);
      step(0, mk(1, 0, 0, 0, 1, 0, 32'h10000, 0, 5'd6));

      // Flush on the 10th BUSY cycle aborts the MUL
      clr(); if0.ALUControl = 4'b1001; if0.RD1 = 7; if0.RD2 = 9; if0.RegWrite = 1; if0.Rt = 1;
      for (int i = 0; i < 10; i++) step(1, '0);
      if0.Flush_E = 1;
      step(0, '0);
      clr(); if0.ALUControl = 4'b0010; if0.RD1 = 1; if0.RD2 = 1; if0.RegWrite = 1; if0.Rt = 2;
      step(0, mk(1, 0, 0, 0, 0, 32'd2, 32'd1, 0, 5'd2));

      // Flush coinciding with a MUL arriving in IDLE must not start it
      clr(); if0.ALUControl = 4'b1001; if0.RD1 = 7; if0.RD2 = 9; if0.RegWrite = 1; if0.Flush_E = 1;
      step(0, '0);
      clr(); if0.ALUControl = 4'b0010; if0.RD1 = 2; if0.RD2 = 3; if0.RegWrite = 1; if0.Rt = 3;
      step(0, mk(1, 0, 0, 0, 0, 32'd5, 32'd3, 0, 5'd3));

      // Reset on the 5th BUSY cycle
      clr(); if0.ALUControl = 4'b1001; if0.RD1 = 3; if0.RD2 = 5; if0.RegWrite = 1;
      for (int i = 0; i < 5; i++) step(1, '0);
      rst = 1'b1;
      step(0, '0);
      rst = 1'b0;
      clr(); if0.ALUControl = 4'b0010; if0.RD1 = 2; if0.RD2 = 2; if0.RegWrite = 1; if0.Rt = 1;
      step(0, mk(1, 0, 0, 0, 0, 32'd4, 32'd2, 0, 5'd1));

      // MUL on both builds: the MUL_ENABLE=0 copy yields 0 with Zero set, no stall
      clr(); if0.ALUControl = 4'b1001; if0.RD1 = 3; if0.RD2 = 5; if0.RegWrite = 1; if0.Rt = 8;
      o1 = mk(1, 0, 0, 0, 1, 0, 32'd5, 0, 5'd8);
      step(1, '0);
      for (int i = 0; i < 32; i++) step(1, '0, 1'b1, o1);
      step(0, mk(1, 0, 0, 0, 0, 32'd15, 32'd5, 0, 5'd8), 1'b1, o1);
      clr();
      step(0, nop, 1'b1, o1);
      step(0, nop);
      @(negedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_stage_mdu.md
Name: ex_stage_mdu

Overview:
- Consumer end of the ID/EX pipeline interface: takes every field the ID/EX register drives and performs the EX stage of the 5-stage pipelined CPU.
- Computes the ALU result, write-register select, branch target and zero flag, then registers them into the EX/MEM pipeline outputs.
- Contains an iterative shift-add multiplier (MUL). While a MUL is in progress it asserts Stall to freeze upstream and inserts bubbles downstream.

Parameters:
- WIDTH, 32, datapath width. MUL iteration count equals WIDTH.
- MUL_ENABLE, 1, 0 = ALUControl 4'b1001 is treated as reserved: result 0, no stall.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  reset, synchronous, active-high.
- RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSrc_shamt, RegDst  input  1 each  control fields from ID/EX.
- ALUControl  input  4  ALU operation.
- RD1, RD2, SignImm, PCplus4  input  WIDTH each  operands from ID/EX.
- Rt, Rd, shamt  input  5 each  register and shift fields from ID/EX.
- Flush_E  input  1  squash the instruction currently in EX.
- Stall  output  1  combinational; freezes PC, IF/ID and ID/EX while 1.
- RegWrite_M, MemtoReg_M, MemWrite_M, Branch_M, Zero_M  output  1 each  registered EX/MEM control and flag.
- ALUOut_M, WriteData_M, PCBranch_M  output  WIDTH each  registered EX/MEM data.
- WriteReg_M  output  5  registered destination register.

Behaviour:
- Reset: RST is synchronous and active-high. On a posedge with RST=1, every registered output becomes 0 and the FSM goes to IDLE. Stall is forced to 0 while RST=1. Reset during a MUL aborts it and discards the partial product.
- Operand selection:
  - SrcA = ALUSrc_shamt ? zero-extended shamt : RD1.
  - SrcB = ALUSrc ? SignImm : RD2.
- ALUControl encoding:
  - 0000 AND; 0001 OR; 0010 ADD (wrap, no overflow trap); 0110 SUB; 0111 SLT (signed, result 1 or 0); 1100 NOR; 1000 XOR.
  - 0011 SLL, 0100 SRL, 0101 SRA: SrcB shifted by SrcA[4:0].
  - 1001 MUL: low WIDTH bits of SrcA*SrcB.
  - All other codes: result 0.
- Derived values:
  - Zero = (result == 0).
  - WriteReg = RegDst ? Rd : Rt.
  - WriteData = RD2.
  - PCBranch = PCplus4 + (SignImm << 2), truncated to WIDTH.
- Single-cycle operations: when not stalling, all EX/MEM outputs load the computed values at the next posedge. Latency is 1 cycle.
- MUL FSM, states IDLE, BUSY, DONE:
  - IDLE with ALUControl=1001 and MUL_ENABLE=1:
    - Stall=1.
    - Latch mcand=SrcA, mplier=SrcB, acc=0, cnt=0.
    - Go to BUSY.
  - BUSY, Stall=1, each cycle:
    - If mplier[0], acc += mcand.
    - mcand <<= 1; mplier >>= 1; cnt++.
    - After WIDTH iterations (cnt reaches WIDTH-1 this cycle), go to DONE.
  - DONE, Stall=0:
    - EX/MEM loads acc as ALUOut_M, Zero_M = (acc == 0), and the MUL instruction's controls, WriteReg and PCBranch.
    - Return to IDLE.
  - Total EX occupancy is WIDTH+2 cycles (34 at default). The result appears at ALUOut_M WIDTH+2 posedges after the MUL enters EX.
  - While Stall=1, EX/MEM loads a bubble: RegWrite_M, MemWrite_M, MemtoReg_M and Branch_M are 0; data outputs are don't-care and must be driven 0.
  - Upstream holds the ID/EX fields stable while Stall=1. The latched operands are authoritative; fields are re-read only in DONE for controls.
- Flush_E (priority RST > Flush_E > normal):
  - Forces a bubble into EX/MEM.
  - In BUSY or DONE it aborts the MUL: go to IDLE, Stall=0 in that cycle.
  - A Flush_E that coincides with a MUL arriving in IDLE does not start the MUL.
- Back-to-back MULs: the second MUL starts from IDLE on the cycle after DONE.

Test Plan:
- Reset: RST=1 for 1 cycle with non-zero inputs -> all _M outputs 0, Stall 0. RST=0, ADD RD1=5, RD2=7 -> next cycle ALUOut_M=12, Zero_M=0, RegWrite_M follows input.
- ALU sweep: SUB 3-3 -> ALUOut_M=0, Zero_M=1. SLT 0xFFFFFFFF vs 1 -> 1. SRA with ALUSrc_shamt=1, shamt=4, RD2=0x80000000 -> 0xF8000000. RegDst=1, Rd=9 -> WriteReg_M=9. PCplus4=0x100, SignImm=0xFFFFFFFF -> PCBranch_M=0xFC.
- MUL: RD1=0x12345, RD2=0x10, RegWrite=1 -> Stall=1 for exactly 33 cycles, 33 bubbles with RegWrite_M=0, then ALUOut_M=0x123450 with RegWrite_M=1 on the 34th posedge.
- MUL signed low word: 0xFFFFFFFF * 2 -> 0xFFFFFFFE. Back-to-back MULs -> two 34-cycle windows with no gap cycle of wrong data.
- Flush_E asserted at cycle 10 of BUSY -> bubble, FSM IDLE, Stall 0 the same cycle, no MUL result written. RST at cycle 5 of BUSY -> outputs 0, Stall 0.
- MUL_ENABLE=0 build: ALUControl=1001 -> ALUOut_M=0, Zero_M=1, Stall never asserted.
